// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD counter slice.
//   BCD_W          width of one decade digit
//   BCD_MAX        largest legal digit value
//   MAX_DIGITS     widest counter supported by the helpers
//   is_bcd()       1 when a nibble holds a legal decimal digit
//   all_digits_eq  1 when the low n digits of a vector all equal val
package bcd_pkg;

  localparam int          BCD_W      = 4;
  localparam logic [3:0]  BCD_MAX    = 4'd9;
  localparam int          MAX_DIGITS = 8;

  function automatic logic is_bcd(input logic [BCD_W-1:0] nib);
    return (nib <= BCD_MAX);
  endfunction

  function automatic logic all_digits_eq(input logic [MAX_DIGITS*BCD_W-1:0] v,
                                         input logic [BCD_W-1:0]            val,
                                         input int                          n);
    logic r;
    r = 1'b1;
    for (int k = 0; k < MAX_DIGITS; k++)
      if (k < n && v[k*BCD_W +: BCD_W] != val) r = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade cell of the BCD counter.
//   CLK, CLR  clock and asynchronous active-high clear (shared with the top)
//   inc, dec  step the digit up/down by one, wrapping 9->0 and 0->9
//   load, d   parallel load; d is already validated by the caller
//   q         current digit value
//   at9, at0  digit is at 9 / 0, used to build the ripple carry/borrow
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             CLK,
  input  logic             CLR,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q,
  output logic             at9,
  output logic             at0
);

  assign at9 = (q == BCD_MAX);
  assign at0 = (q == '0);

  // The top never asserts more than one of load/inc/dec, so the order
  // below only matters for robustness.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)       q <= '0;
    else if (load) q <= d;
    else if (inc)  q <= at9 ? '0 : q + 4'd1;
    else if (dec)  q <= at0 ? BCD_MAX : q - 4'd1;
  end

endmodule

// File: rtl/bcd_counter_ndigit.sv
// Multi-digit BCD up/down counter built from cascaded decade cells.
//   CLK, CLR   clock, asynchronous active-high clear of all state
//   ENABLE     qualifies both counting and loading
//   LOAD, D    parallel load; rejected when any nibble of D exceeds 9
//   UP         count direction (1 = up)
//   Q          counter value, digit k in Q[4k+3:4k]
//   CO         registered pulse after an enabled count at the terminal value
//   RCO        combinational cascade carry, drives the next ENABLE
//   LOAD_ERR   registered one-cycle pulse on a rejected load
module bcd_counter_ndigit
  import bcd_pkg::*;
#(
  parameter int NDIGITS  = 4,
  parameter bit SATURATE = 1'b0
)(
  input  logic                     CLK,
  input  logic                     CLR,
  input  logic                     ENABLE,
  input  logic                     LOAD,
  input  logic                     UP,
  input  logic [BCD_W*NDIGITS-1:0] D,
  output logic [BCD_W*NDIGITS-1:0] Q,
  output logic                     CO,
  output logic                     RCO,
  output logic                     LOAD_ERR
);

  logic [NDIGITS-1:0] at9, at0, inc, dec, dig_ok;
  logic [NDIGITS:0]   carry, borrow;
  logic               count_req, term, cnt_en, d_ok, load_ok, load_bad;

  // carry[k]/borrow[k]: every digit below k is at 9 / at 0. The top bit of
  // each chain is the terminal-count condition for that direction.
  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < NDIGITS; g++) begin : g_dig
    assign carry[g+1]  = carry[g]  & at9[g];
    assign borrow[g+1] = borrow[g] & at0[g];
    assign dig_ok[g]   = is_bcd(D[g*BCD_W +: BCD_W]);
    assign inc[g]      = cnt_en &  UP & carry[g];
    assign dec[g]      = cnt_en & ~UP & borrow[g];

    bcd_digit u_dig (
      .CLK  (CLK),
      .CLR  (CLR),
      .inc  (inc[g]),
      .dec  (dec[g]),
      .load (load_ok),
      .d    (D[g*BCD_W +: BCD_W]),
      .q    (Q[g*BCD_W +: BCD_W]),
      .at9  (at9[g]),
      .at0  (at0[g])
    );
  end

  assign count_req = ENABLE & ~LOAD;
  assign term      = UP ? carry[NDIGITS] : borrow[NDIGITS];
  assign RCO       = count_req & term;
  // Wrap falls out of the per-digit 9->0 / 0->9 rule; saturation just
  // suppresses the step at the terminal value.
  assign cnt_en    = count_req & ~(SATURATE & term);

  assign d_ok      = &dig_ok;
  assign load_ok   = ENABLE & LOAD &  d_ok;
  assign load_bad  = ENABLE & LOAD & ~d_ok;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      CO       <= 1'b0;
      LOAD_ERR <= 1'b0;
    end else begin
      CO       <= RCO;
      LOAD_ERR <= load_bad;
    end
  end

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Scoreboard bench: the driver pushes the expected outputs for each cycle,
// a negedge monitor pops and compares against the selected instance.
// Instance 0 wraps, instance 1 saturates; the idle one has ENABLE low.
module tb_bcd_counter_ndigit;

  logic        clk = 1'b0;
  logic        clr;
  logic [1:0]  en;
  logic        ld, up;
  logic [15:0] d;
  logic [15:0] q [2];
  logic [1:0]  co, rco, err;

  always #5 clk = ~clk;

  bcd_counter_ndigit #(.NDIGITS(4), .SATURATE(1'b0)) dut0 (
    .CLK(clk), .CLR(clr), .ENABLE(en[0]), .LOAD(ld), .UP(up), .D(d),
    .Q(q[0]), .CO(co[0]), .RCO(rco[0]), .LOAD_ERR(err[0]));

  bcd_counter_ndigit #(.NDIGITS(4), .SATURATE(1'b1)) dut1 (
    .CLK(clk), .CLR(clr), .ENABLE(en[1]), .LOAD(ld), .UP(up), .D(d),
    .Q(q[1]), .CO(co[1]), .RCO(rco[1]), .LOAD_ERR(err[1]));

  typedef struct {
    int          s;
    logic [15:0] q;
    logic        co, err, rco;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] cur_q   [2] = '{16'h0, 16'h0};
  logic        cur_co  [2] = '{1'b0, 1'b0};
  logic        cur_err [2] = '{1'b0, 1'b0};

  task automatic chk(input string nm, input int s, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %h want %h", nm, s, $time, act, exp);
    end
  endtask

  // Monitor: sample mid-cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("Q",        e.s, q[e.s],          e.q);
      chk("CO",       e.s, 16'(co[e.s]),    16'(e.co));
      chk("LOAD_ERR", e.s, 16'(err[e.s]),   16'(e.err));
      chk("RCO",      e.s, 16'(rco[e.s]),   16'(e.rco));
    end
  end

  // Apply one cycle of stimulus just after a posedge, push what the selected
  // instance must show before the next edge, then record the hand-computed
  // state it must hold after that edge.
  task automatic step(input int s, input logic c, input logic e, input logic l,
                      input logic u, input logic [15:0] dv, input logic xrco,
                      input logic [15:0] nq, input logic nco, input logic nerr);
    exp_t it;
    clr = c; en = '0; en[s] = e; ld = l; up = u; d = dv;
    if (c) for (int k = 0; k < 2; k++) begin
      cur_q[k] = '0; cur_co[k] = 1'b0; cur_err[k] = 1'b0;
    end
    it.s = s; it.q = cur_q[s]; it.co = cur_co[s]; it.err = cur_err[s]; it.rco = xrco;
    sb.push_back(it);
    @(posedge clk); #1;
    cur_q[s] = nq; cur_co[s] = nco; cur_err[s] = nerr;
    cur_co[1-s] = 1'b0; cur_err[1-s] = 1'b0;
    if (c) cur_q[1-s] = '0;
  endtask

  logic [15:0] up12 [12] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006,
                             16'h0007, 16'h0008, 16'h0009, 16'h0010, 16'h0011, 16'h0012};

  initial begin
    clr = 1'b1; en = '0; ld = 1'b0; up = 1'b1; d = '0;
    @(posedge clk); #1;
    //   s  clr en ld up  D         rco  next Q    CO   ERR
    step(0, 1, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, 0);   // reset state
    for (int i = 0; i < 12; i++)
      step(0, 0, 1, 0, 1, 16'h0000, 0, up12[i], 0, 0);
    step(0, 0, 1, 1, 1, 16'h0999, 0, 16'h0999, 0, 0);
    step(0, 0, 1, 0, 1, 16'h0000, 0, 16'h1000, 0, 0);   // ripple carry across 3 digits
    step(0, 0, 1, 1, 1, 16'h9999, 0, 16'h9999, 0, 0);
    step(0, 0, 1, 0, 1, 16'h0000, 1, 16'h0000, 1, 0);   // wrap up, RCO before edge
    step(0, 0, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, 0);   // CO visible one cycle only
    step(0, 0, 1, 1, 0, 16'h1000, 0, 16'h1000, 0, 0);
    step(0, 0, 1, 0, 0, 16'h0000, 0, 16'h0999, 0, 0);   // ripple borrow
    step(0, 0, 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 0);
    step(0, 0, 1, 0, 0, 16'h0000, 1, 16'h9999, 1, 0);   // wrap down
    step(0, 0, 1, 1, 0, 16'h12A4, 0, 16'h9999, 0, 1);   // rejected load
    step(0, 0, 0, 1, 0, 16'h12A4, 0, 16'h9999, 0, 0);   // ENABLE low: no error
    step(0, 0, 0, 0, 1, 16'h0000, 0, 16'h9999, 0, 0);
    // saturating instance
    step(1, 0, 1, 1, 1, 16'h9999, 0, 16'h9999, 0, 0);
    for (int i = 0; i < 3; i++)
      step(1, 0, 1, 0, 1, 16'h0000, 1, 16'h9999, 1, 0);
    step(1, 0, 1, 0, 0, 16'h0000, 0, 16'h9998, 0, 0);   // direction flip leaves TERM
    step(1, 0, 0, 0, 0, 16'h0000, 0, 16'h9998, 0, 0);
    // async clear mid-count
    step(0, 0, 1, 1, 1, 16'h0456, 0, 16'h0456, 0, 0);
    step(0, 0, 1, 0, 1, 16'h0000, 0, 16'h0457, 0, 0);
    step(0, 1, 1, 0, 1, 16'h0000, 0, 16'h0000, 0, 0);   // CLR between edges
    step(0, 0, 1, 0, 1, 16'h0000, 0, 16'h0001, 0, 0);
    step(0, 0, 0, 0, 1, 16'h0000, 0, 16'h0001, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
